// File: rtl/shift_arbiter_if.sv
// Bundle of requester, shifter and response signals around the shared barrel shifter.
// The arbiter uses the slave modport; the surrounding system uses master.
interface shift_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [1:0]  req0_op;
  logic [31:0] req0_data;
  logic [4:0]  req0_amt;

  logic        req1_valid;
  logic        req1_ready;
  logic [1:0]  req1_op;
  logic [31:0] req1_data;
  logic [4:0]  req1_amt;

  logic [31:0] sh_din;
  logic [4:0]  sh_func;
  logic [4:0]  sh_shft_amnt;
  logic [31:0] sh_dout;
  logic        sh_c;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_n;
  logic        rsp_z;
  logic        rsp_c;

  modport slave (
    input  req0_valid, req0_op, req0_data, req0_amt,
    input  req1_valid, req1_op, req1_data, req1_amt,
    input  sh_dout, sh_c, rsp_ready,
    output req0_ready, req1_ready,
    output sh_din, sh_func, sh_shft_amnt,
    output rsp_valid, rsp_id, rsp_data, rsp_n, rsp_z, rsp_c
  );

  modport master (
    output req0_valid, req0_op, req0_data, req0_amt,
    output req1_valid, req1_op, req1_data, req1_amt,
    output sh_dout, sh_c, rsp_ready,
    input  req0_ready, req1_ready,
    input  sh_din, sh_func, sh_shft_amnt,
    input  rsp_valid, rsp_id, rsp_data, rsp_n, rsp_z, rsp_c
  );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin front end for the shared 32-bit barrel shifter; builds rotate-right
// from an SRL pass followed by an SLL pass OR-ed into the accumulator.
module shift_arbiter (
  input  logic            clk,
  input  logic            reset_n,
  shift_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_e;
  typedef enum logic [1:0] {OP_SLL, OP_SRL, OP_SRA, OP_ROR} op_e;

  localparam logic [4:0] FUNC_NONE = 5'h00;
  localparam logic [4:0] FUNC_SLL  = 5'h0C;
  localparam logic [4:0] FUNC_SRL  = 5'h0D;
  localparam logic [4:0] FUNC_SRA  = 5'h0E;

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [31:0] data_q, data_d;
  logic [4:0]  amt_q, amt_d;
  logic        id_q, id_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] acc_q, acc_d;
  logic        c_q, c_d;
  logic        rsp_valid_q, rsp_valid_d;

  logic        grant0;
  logic        grant1;

  always_comb begin
    grant0 = bus.req0_valid && (!bus.req1_valid || last_grant_q);
    grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant_q);

    bus.req0_ready = reset_n && (state_q == IDLE) && grant0;
    bus.req1_ready = reset_n && (state_q == IDLE) && grant1;

    state_d      = state_q;
    op_d         = op_q;
    data_d       = data_q;
    amt_d        = amt_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    acc_d        = acc_q;
    c_d          = c_q;
    rsp_valid_d  = rsp_valid_q;

    bus.sh_din       = 32'h0;
    bus.sh_func      = FUNC_NONE;
    bus.sh_shft_amnt = 5'h0;

    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          op_d         = grant1 ? op_e'(bus.req1_op) : op_e'(bus.req0_op);
          data_d       = grant1 ? bus.req1_data : bus.req0_data;
          amt_d        = grant1 ? bus.req1_amt  : bus.req0_amt;
          id_d         = grant1;
          last_grant_d = grant1;
          state_d      = PASS1;
        end
      end
      PASS1: begin
        bus.sh_din       = data_q;
        bus.sh_shft_amnt = amt_q;
        case (op_q)
          OP_SLL:  bus.sh_func = FUNC_SLL;
          OP_SRA:  bus.sh_func = FUNC_SRA;
          default: bus.sh_func = FUNC_SRL;
        endcase
        acc_d = bus.sh_dout;
        c_d   = (op_q == OP_SRA) ? bus.sh_c : 1'b0;
        // A zero-amount rotate is already complete after the SRL-by-0 pass.
        if (op_q == OP_ROR && amt_q != 5'd0) begin
          state_d = PASS2;
        end else begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
        end
      end
      PASS2: begin
        bus.sh_din       = data_q;
        bus.sh_func      = FUNC_SLL;
        bus.sh_shft_amnt = (~amt_q) + 5'd1;
        acc_d            = acc_q | bus.sh_dout;
        state_d          = DONE;
        rsp_valid_d      = 1'b1;
      end
      DONE: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      op_q         <= OP_SLL;
      data_q       <= 32'h0;
      amt_q        <= 5'h0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      acc_q        <= 32'h0;
      c_q          <= 1'b0;
      rsp_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      data_q       <= data_d;
      amt_q        <= amt_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      acc_q        <= acc_d;
      c_q          <= c_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = acc_q;
  assign bus.rsp_n     = acc_q[31];
  assign bus.rsp_z     = (acc_q == 32'h0);
  assign bus.rsp_c     = c_q;

endmodule
